// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  localparam int MIN_DATA_BITS = 5;

  // Data-bit count from the "bits minus one" field, clamped to [MIN_DATA_BITS, max_bits].
  function automatic logic [3:0] clamp_bits(input logic [3:0] ds, input int max_bits);
    int n;
    n = int'(ds) + 1;
    if (n > max_bits)
      clamp_bits = 4'(max_bits);
    else if (n < MIN_DATA_BITS)
      clamp_bits = 4'(MIN_DATA_BITS);
    else
      clamp_bits = 4'(n);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for an asynchronous serial line; idles high after reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_chain <= '1;
    else
      r_chain <= {r_chain[STAGES-2:0], d_i};
  end

  assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampled UART receiver with break detection and a one-entry output holding register.
// Build option UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [15:0]       cr_clk_div_i,
  input  logic [3:0]        cr_ds_i,
  input  logic [1:0]        cr_p_i,
  input  logic              cr_s_i,
  input  logic              uart_rx_i,
  output logic [DATA_W-1:0] data_o,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              break_o,
  output logic              output_valid_o,
  input  logic              output_ready_i,
  output logic              overrun_o
);

  localparam int HALF  = OVERSAMPLE / 2;
  localparam int CNT_W = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_CNT = HALF;
`else
  localparam int DEC_CNT = HALF - 1;
`endif

  logic              w_rx;
  logic              r_rx_d;
  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic [15:0]       r_div;
  logic [15:0]       r_clk_div;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [3:0]        r_nbits;
  logic [3:0]        r_bit_cnt;
  logic [1:0]        r_par;
  logic              r_stop2;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_bit_sel;
  logic              r_par_acc;
  logic              r_zero;
  logic              r_perr;
  logic              r_ferr;
  logic              r_cmp;
  logic              r_cmp_brk;
  logic [DATA_W-1:0] r_data;
  logic              r_hold_perr;
  logic              r_hold_ferr;
  logic              r_hold_brk;
  logic              r_valid;
  logic              r_overrun;
  logic              w_tick;
  logic              w_decide;
  logic              w_bit;
  logic              w_start_edge;
  logic              w_par_en;
  logic              w_last_data;
  logic              w_cmp;
  logic              w_brk;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (uart_rx_i),
    .q_o   (w_rx)
  );

  assign w_tick       = (r_state != ST_IDLE) && (r_div == r_clk_div);
  assign w_decide     = w_tick && (r_tick_cnt == CNT_W'(DEC_CNT));
  assign w_start_edge = (r_state == ST_IDLE) && r_rx_d && !w_rx;
  assign w_par_en     = (r_par == PARITY_EVEN) || (r_par == PARITY_ODD);
  assign w_last_data  = (r_bit_cnt == r_nbits - 4'd1);

`ifdef UART_RX_MAJORITY_EN
  logic r_s_a;
  logic r_s_b;

  // The first two of three samples; the third is the live line at the decision tick.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_s_a <= 1'b1;
      r_s_b <= 1'b1;
    end else if (w_tick) begin
      if (r_tick_cnt == CNT_W'(HALF - 2)) r_s_a <= w_rx;
      if (r_tick_cnt == CNT_W'(HALF - 1)) r_s_b <= w_rx;
    end
  end

  assign w_bit = (r_s_a & r_s_b) | (r_s_a & w_rx) | (r_s_b & w_rx);
`else
  assign w_bit = w_rx;
`endif

  genvar gi;
  for (gi = 0; gi < DATA_W; gi++) begin : g_bit_sel
    assign w_bit_sel[gi] = (r_bit_cnt == 4'(gi));
  end

  always_comb begin
    w_state_next = r_state;
    w_cmp        = 1'b0;
    w_brk        = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_start_edge) w_state_next = ST_START;
      ST_START:  if (w_decide) w_state_next = w_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_decide && w_last_data) w_state_next = w_par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: if (w_decide) w_state_next = ST_STOP1;
      ST_STOP1: begin
        if (w_decide) begin
          if (r_zero && !w_bit) begin
            w_brk        = 1'b1;
            w_cmp        = 1'b1;
            w_state_next = ST_BRK_WAIT;
          end else if (r_stop2) begin
            w_state_next = ST_STOP2;
          end else begin
            w_cmp        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_STOP2: begin
        if (w_decide) begin
          w_cmp        = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_BRK_WAIT: if (w_rx) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // Frame datapath; r_shift/r_perr/r_ferr stay intact for the cycle after completion.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rx_d     <= 1'b1;
      r_div      <= '0;
      r_clk_div  <= '0;
      r_tick_cnt <= '0;
      r_nbits    <= 4'd0;
      r_bit_cnt  <= 4'd0;
      r_par      <= PARITY_NONE;
      r_stop2    <= 1'b0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_zero     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_cmp      <= 1'b0;
      r_cmp_brk  <= 1'b0;
    end else begin
      r_rx_d    <= w_rx;
      r_cmp     <= w_cmp;
      r_cmp_brk <= w_brk;

      if (r_state == ST_IDLE || w_tick)
        r_div <= '0;
      else
        r_div <= r_div + 16'd1;

      if (r_state == ST_IDLE)
        r_tick_cnt <= '0;
      else if (w_tick)
        r_tick_cnt <= (r_tick_cnt == CNT_W'(OVERSAMPLE - 1)) ? '0 : r_tick_cnt + 1'b1;

      if (w_start_edge) begin
        r_clk_div <= cr_clk_div_i;
        r_nbits   <= clamp_bits(cr_ds_i, DATA_W);
        r_par     <= cr_p_i;
        r_stop2   <= cr_s_i;
        r_bit_cnt <= 4'd0;
        r_shift   <= '0;
        r_par_acc <= 1'b0;
        r_zero    <= 1'b1;
        r_perr    <= 1'b0;
        r_ferr    <= 1'b0;
      end

      if (w_decide) begin
        case (r_state)
          ST_DATA: begin
            r_shift   <= r_shift | ({DATA_W{w_bit}} & w_bit_sel);
            r_par_acc <= r_par_acc ^ w_bit;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_bit) r_zero <= 1'b0;
          end
          ST_PARITY: begin
            r_perr <= r_par_acc ^ w_bit ^ (r_par == PARITY_ODD);
            if (w_bit) r_zero <= 1'b0;
          end
          ST_STOP1, ST_STOP2: if (!w_bit) r_ferr <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // A completing frame is accepted if the slot is empty or is being drained this cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_data      <= '0;
      r_hold_perr <= 1'b0;
      r_hold_ferr <= 1'b0;
      r_hold_brk  <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && output_ready_i)
        r_valid <= 1'b0;
      if (r_cmp) begin
        if (!r_valid || output_ready_i) begin
          r_data      <= r_shift;
          r_hold_perr <= r_perr & ~r_cmp_brk;
          r_hold_ferr <= r_ferr;
          r_hold_brk  <= r_cmp_brk;
          r_valid     <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign data_o         = r_data;
  assign parity_err_o   = r_hold_perr;
  assign frame_err_o    = r_hold_ferr;
  assign break_o        = r_hold_brk;
  assign output_valid_o = r_valid;
  assign overrun_o      = r_overrun;

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Parametrised UART receive engine; next generation of the rx frontend. Adds a programmable data width, an oversampled bit clock with false-start rejection, majority-vote sampling, break detection and a one-entry output holding register with a valid/ready handshake and overrun reporting. Sits between the synchronised uart_rx pin and the RX FIFO / Wishbone register block.

Parameters:
DATA_W, 8, maximum data bits per frame (5..9)
OVERSAMPLE, 16, sample ticks per bit (even, >=4)
SYNC_STAGES, 2, rx input synchroniser depth (>=2)

Ports:
clk_i  in  1  single clock
rst_i  in  1  reset, synchronous, active-low
cr_clk_div_i  in  16  sample tick every cr_clk_div_i+1 clocks
cr_ds_i  in  4  data bits minus 1; values >DATA_W-1 clamp to DATA_W, <4 clamp to 5
cr_p_i  in  2  parity: 00 none, 01 even, 10 odd, 11 none
cr_s_i  in  1  0 = one stop bit, 1 = two stop bits
uart_rx_i  in  1  asynchronous serial input
data_o  out  DATA_W  received data, LSB first on line, right-aligned, unused MSBs 0
parity_err_o  out  1  qualified by output_valid_o
frame_err_o  out  1  a stop bit sampled 0; qualified by output_valid_o
break_o  out  1  break frame; qualified by output_valid_o
output_valid_o  out  1  holding register full
output_ready_i  in  1  consumer accepts when valid & ready
overrun_o  out  1  one-cycle pulse: completed frame dropped

Behaviour:
- Reset (rst_i=0 at posedge): state IDLE, tick counter 0, holding empty; all outputs 0. Synchroniser preset to 1. A frame in progress is discarded.
- Tick generator: divider counter is free-running in every state except IDLE. It restarts at the start edge.
- Config (cr_*) is latched at start detection. Changes mid-frame do not affect that frame.
- FSM: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
- IDLE -> START on a synchronised 1->0 transition.
- START: at mid-bit (tick OVERSAMPLE/2) the line is sampled. A sample of 1 is a false start -> IDLE with no output. A sample of 0 -> DATA.
- DATA: one sample per OVERSAMPLE ticks at mid-bit, shifted in LSB first. After N bits -> PARITY if parity is enabled, else STOP1.
- PARITY: check against the XOR of the data bits. Even: XOR of data and parity must be 0. Odd: it must be 1.
- STOP1 -> STOP2 if cr_s_i=1, else complete. STOP2 -> complete. frame_err is set if any stop sample is 0.
- Break: all data bits 0, parity sample 0 (if enabled) and STOP1 sample 0. break_o=1, frame_err_o=1, parity_err_o=0, data_o=0. STOP2 is skipped and the FSM goes to BRK_WAIT, which waits for a synchronised 1 before IDLE.
- Completion: the frame is written to the holding register the cycle after the final stop-bit mid sample. The FSM returns to IDLE in that same cycle, so a start edge can be detected half a bit early.
- Handshake: output_valid_o is held until valid & output_ready_i. data_o and the flags are stable while valid.
- Completion with holding full and no accept that cycle: new frame dropped, overrun_o pulses for 1 cycle, old frame kept.
- Completion with valid & ready in the same cycle: the new frame is loaded, valid stays 1, no overrun.
- Input latency: SYNC_STAGES clocks from pin to FSM.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit (start, data, parity, stop) is the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is taken at tick OVERSAMPLE/2+1.
- Undefined: single sample at tick OVERSAMPLE/2.
- Completion timing follows the decision tick.

Decomposition:
- Package uart_pkg: rx_state_t enum; parity encodings PARITY_NONE/EVEN/ODD; MIN_DATA_BITS=5.
- Sub-module uart_sync (SYNC_STAGES flop chain, reset to 1) is natural and reusable by the TX loopback path. The FSM stays in uart_rx_engine.

Test Plan:
- cr_clk_div_i=0, OVERSAMPLE=16, 8N1, send 0xA5, ready=1 -> data_o=0xA5, all flags 0, valid for 1 cycle. Valid rises 8*16+16+8+1+SYNC_STAGES clocks after the start edge (no majority).
- 7E2 (cr_ds_i=6, cr_p_i=01, cr_s_i=1), send 0x55 with wrong parity bit 1 -> data_o=0x55, parity_err_o=1. Same frame with second stop=0 -> frame_err_o=1.
- Line low for 5 ticks then high (glitch) -> no valid, FSM back in IDLE. Line low 8N1 for 12 bit times -> break_o=1, frame_err_o=1, data_o=0. No new frame until the line has been high.
- ready=0, send 0x11 then 0x22 -> data_o stays 0x11 and overrun_o pulses once. Ready asserted in the completion cycle of 0x22 -> data_o=0x22, no overrun.
- Majority enabled: 1-tick glitch at the centre of each data bit of 0x3C -> data_o=0x3C. Disabled -> corrupted value.
- rst_i=0 for 1 cycle during DATA of a frame -> outputs 0, no valid for the remainder, the next full frame is received correctly.
